// File: rtl/cl_cfg_reg_rsp.sv
// cl_cfg_reg_rsp: cfg_bus responder with a small register bank and a
// programmable ack delay. One access in flight; ack and rdata are registered.
module cl_cfg_reg_rsp #(
    parameter logic [31:0] ID_VALUE    = 32'h0CF6_0001,
    parameter int unsigned RST_ACK_DLY = 0,
    parameter int unsigned DLY_W       = 8
) (
    input  logic        clk,
    input  logic        sync_rst_n,
    input  logic        flr_assert,
    input  logic [31:0] cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        cfg_wr,
    input  logic        cfg_rd,
    output logic        cfg_ack,
    output logic [31:0] cfg_rdata,
    output logic [31:0] ctrl_out,
    input  logic [31:0] status_in
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OFS_W  = 6;
    localparam int unsigned CYC_W  = 64;
    localparam int unsigned STS_W  = 3;

    localparam logic [OFS_W-1:0] OFS_CTRL    = 6'h00;
    localparam logic [OFS_W-1:0] OFS_SCRATCH = 6'h01;
    localparam logic [OFS_W-1:0] OFS_ACK_DLY = 6'h02;
    localparam logic [OFS_W-1:0] OFS_STATUS  = 6'h03;
    localparam logic [OFS_W-1:0] OFS_WR_CNT  = 6'h04;
    localparam logic [OFS_W-1:0] OFS_RD_CNT  = 6'h05;
    localparam logic [OFS_W-1:0] OFS_CYC_LO  = 6'h06;
    localparam logic [OFS_W-1:0] OFS_CYC_HI  = 6'h07;
    localparam logic [OFS_W-1:0] OFS_ID      = 6'h08;
    localparam logic [OFS_W-1:0] OFS_EXT     = 6'h09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OFS_W-1:0]    addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                is_wr_q;
    logic [DLY_W-1:0]    dly_cnt_q;

    logic [DATA_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   scratch_q, scratch_d;
    logic [DLY_W-1:0]    ack_dly_q, ack_dly_d;
    logic [STS_W-1:0]    status_q, status_d;
    logic [DATA_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0]   cyc_hi_snap_q, cyc_hi_snap_d;
    logic [CYC_W-1:0]    cyc_q;
    logic                ack_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                req_c;
    logic                accept_c;
    logic                access_c;
    logic                overlap_c;
    logic                collide_c;
    logic                unmapped_c;
    logic                wr_hit_c;
    logic                rd_hit_c;
    logic [DATA_W-1:0]   rd_val_c;

    logic                unused_addr;
    assign unused_addr = ^{cfg_addr[31:8], cfg_addr[1:0]};

    assign cfg_ack   = ack_q;
    assign cfg_rdata = rdata_q;
    assign ctrl_out  = ctrl_q;

    // State register
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic; FLR overrides everything
    always_comb begin
        state_d = state_q;
        if (flr_assert) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cfg_wr || cfg_rd) state_d = ST_WAIT;
                ST_WAIT: if (dly_cnt_q == '0) state_d = ST_ACK;
                ST_ACK:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM-derived strobes: accept, perform access, protocol error flags
    always_comb begin
        req_c      = (cfg_wr || cfg_rd) && !flr_assert;
        accept_c   = req_c && (state_q == ST_IDLE);
        overlap_c  = req_c && (state_q != ST_IDLE);
        collide_c  = accept_c && cfg_wr && cfg_rd;
        access_c   = (state_q == ST_WAIT) && (dly_cnt_q == '0) && !flr_assert;
        wr_hit_c   = access_c && is_wr_q;
        rd_hit_c   = access_c && !is_wr_q;
        unmapped_c = access_c && (addr_q > OFS_EXT);
    end

    // Request capture and ack-delay countdown
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            dly_cnt_q <= '0;
        end else if (accept_c) begin
            addr_q    <= cfg_addr[7:2];
            wdata_q   <= cfg_wdata;
            is_wr_q   <= cfg_wr;
            dly_cnt_q <= ack_dly_q;
        end else if (state_q == ST_WAIT && dly_cnt_q != '0) begin
            dly_cnt_q <= dly_cnt_q - DLY_W'(1);
        end
    end

    // Read-data mux, evaluated on the access edge
    always_comb begin
        rd_val_c = 32'hDEAD_BEEF;
        case (addr_q)
            OFS_CTRL:    rd_val_c = ctrl_q;
            OFS_SCRATCH: rd_val_c = scratch_q;
            OFS_ACK_DLY: rd_val_c = DATA_W'(ack_dly_q);
            OFS_STATUS:  rd_val_c = DATA_W'(status_q);
            OFS_WR_CNT:  rd_val_c = wr_cnt_q;
            OFS_RD_CNT:  rd_val_c = rd_cnt_q;
            OFS_CYC_LO:  rd_val_c = cyc_q[31:0];
            OFS_CYC_HI:  rd_val_c = cyc_hi_snap_q;
            OFS_ID:      rd_val_c = ID_VALUE;
            OFS_EXT:     rd_val_c = status_in;
            default:     rd_val_c = 32'hDEAD_BEEF;
        endcase
    end

    // Register bank next state: writes, counters, snapshot, sticky status
    always_comb begin
        ctrl_d        = ctrl_q;
        scratch_d     = scratch_q;
        ack_dly_d     = ack_dly_q;
        status_d      = status_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        cyc_hi_snap_d = cyc_hi_snap_q;
        rdata_d       = rdata_q;

        if (wr_hit_c) begin
            case (addr_q)
                OFS_CTRL:    ctrl_d    = wdata_q;
                OFS_SCRATCH: scratch_d = wdata_q;
                OFS_ACK_DLY: ack_dly_d = wdata_q[DLY_W-1:0];
                OFS_STATUS:  status_d  = status_q & ~wdata_q[STS_W-1:0];
                default:     ;
            endcase
            if (addr_q == OFS_WR_CNT)   wr_cnt_d = '0;
            else if (wr_cnt_q != '1)    wr_cnt_d = wr_cnt_q + DATA_W'(1);
        end

        if (wr_hit_c && addr_q == OFS_RD_CNT)  rd_cnt_d = '0;
        else if (rd_hit_c && rd_cnt_q != '1)   rd_cnt_d = rd_cnt_q + DATA_W'(1);

        if (rd_hit_c) begin
            rdata_d = rd_val_c;
            if (addr_q == OFS_CYC_LO) cyc_hi_snap_d = cyc_q[63:32];
        end

        // Set sources applied last so they win over a same-cycle W1C clear
        status_d = status_d | {unmapped_c, collide_c, overlap_c};
    end

    // Register bank, outputs and free-running cycle counter
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            ctrl_q        <= '0;
            scratch_q     <= '0;
            ack_dly_q     <= DLY_W'(RST_ACK_DLY);
            status_q      <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            cyc_hi_snap_q <= '0;
            cyc_q         <= '0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            scratch_q     <= scratch_d;
            ack_dly_q     <= ack_dly_d;
            status_q      <= status_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            cyc_hi_snap_q <= cyc_hi_snap_d;
            cyc_q         <= cyc_q + CYC_W'(1);
            ack_q         <= access_c;
            rdata_q       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_cl_cfg_reg_rsp.sv
// Directed bench for cl_cfg_reg_rsp: expected acks are queued when a request
// is driven and checked (latency and rdata) when cfg_ack is observed.
module tb_cl_cfg_reg_rsp;

    localparam logic [31:0] ID_VAL = 32'h0CF6_0001;

    logic        clk = 1'b0;
    logic        sync_rst_n;
    logic        flr_assert;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic [31:0] ctrl_out;
    logic [31:0] status_in;

    int errors = 0;
    int checks = 0;
    int tb_cyc = 0;

    logic [31:0] exp_rdata_q[$];
    bit          exp_chk_q[$];
    int          exp_iss_q[$];
    int          exp_lat_q[$];
    string       exp_tag_q[$];

    logic [31:0] last_rd;
    bit          last_rd_known;

    cl_cfg_reg_rsp dut (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .flr_assert (flr_assert),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_wr     (cfg_wr),
        .cfg_rd     (cfg_rd),
        .cfg_ack    (cfg_ack),
        .cfg_rdata  (cfg_rdata),
        .ctrl_out   (ctrl_out),
        .status_in  (status_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample at negedge; any ack must match the head of the scoreboard
    task automatic observe();
        int lat;
        logic [31:0] er;
        bit ec;
        string tg;
        if (cfg_ack === 1'b1) begin
            checks++;
            assert (exp_lat_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_ack: observed ack at cycle %0d, expected no ack", tb_cyc);
            end
            if (exp_lat_q.size() != 0) begin
                er  = exp_rdata_q.pop_front();
                ec  = exp_chk_q.pop_front();
                lat = tb_cyc - exp_iss_q.pop_front();
                tg  = exp_tag_q.pop_front();
                check32({tg, "_lat"}, 32'(lat), 32'(exp_lat_q.pop_front()));
                if (ec) check32({tg, "_rdata"}, cfg_rdata, er);
            end
        end
    endtask

    // Advance one cycle: observe at negedge, return at posedge + 1
    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_wr    = w;
        cfg_rd    = r;
        tick();
        cfg_wr    = 1'b0;
        cfg_rd    = 1'b0;
    endtask

    task automatic push_exp(input bit is_wr, input logic [31:0] rdata, input bit chk,
                            input int lat, input string tag);
        exp_iss_q.push_back(tb_cyc);
        exp_lat_q.push_back(lat);
        exp_tag_q.push_back(tag);
        if (is_wr) begin
            exp_rdata_q.push_back(last_rd);
            exp_chk_q.push_back(last_rd_known);
        end else begin
            exp_rdata_q.push_back(rdata);
            exp_chk_q.push_back(chk);
            last_rd       = rdata;
            last_rd_known = chk;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (exp_lat_q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        assert (exp_lat_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_timeout: observed %0d acks outstanding, expected 0", tag, exp_lat_q.size());
            exp_rdata_q.delete(); exp_chk_q.delete(); exp_iss_q.delete();
            exp_lat_q.delete();   exp_tag_q.delete();
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int lat, input string tag);
        push_exp(1'b1, '0, 1'b0, lat, tag);
        pulse(a, d, 1'b1, 1'b0);
        wait_idle(tag);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input bit chk, input int lat,
                      input string tag);
        push_exp(1'b0, e, chk, lat, tag);
        pulse(a, '0, 1'b0, 1'b1);
        wait_idle(tag);
    endtask

    initial begin
        sync_rst_n = 1'b0;
        flr_assert = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_wr     = 1'b0;
        cfg_rd     = 1'b0;
        status_in  = '0;
        last_rd    = '0;
        last_rd_known = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check32("rst_ack",   32'(cfg_ack), 32'd0);
        check32("rst_rdata", cfg_rdata,    32'd0);
        check32("rst_ctrl",  ctrl_out,     32'd0);
        sync_rst_n = 1'b1;
        tick(); tick();
        rd(32'h08, 32'd0, 1'b1, 2, "rst_ack_dly");

        // Zero delay write/read
        wr(32'h04, 32'hA5A5_0001, 2, "wr_scratch");
        rd(32'h04, 32'hA5A5_0001, 1'b1, 2, "rd_scratch");

        // Delay 5: ack exactly 5 cycles later than zero-delay
        wr(32'h08, 32'd5, 2, "wr_dly5");
        rd(32'h20, ID_VAL, 1'b1, 7, "rd_id_dly5");
        rd(32'h08, 32'd5, 1'b1, 7, "rd_dly5");

        // Delay 3, overlapping pulse dropped and flagged
        wr(32'h08, 32'd3, 7, "wr_dly3");
        push_exp(1'b0, 32'hA5A5_0001, 1'b1, 5, "rd_ovl_first");
        pulse(32'h04, '0, 1'b0, 1'b1);
        pulse(32'h04, '0, 1'b0, 1'b1);
        wait_idle("rd_ovl_first");
        repeat (4) tick();
        rd(32'h0C, 32'h1, 1'b1, 5, "status_ovl");
        wr(32'h0C, 32'h1, 5, "w1c_ovl");
        rd(32'h0C, 32'h0, 1'b1, 5, "status_clr");

        // Unmapped access and wr+rd collision
        rd(32'h40, 32'hDEAD_BEEF, 1'b1, 5, "rd_unmapped");
        rd(32'h0C, 32'h4, 1'b1, 5, "status_unmap");
        wr(32'h0C, 32'h7, 5, "w1c_all");
        push_exp(1'b1, '0, 1'b0, 5, "wr_rd_collide");
        pulse(32'h00, 32'd7, 1'b1, 1'b1);
        wait_idle("wr_rd_collide");
        check32("ctrl_out_7", ctrl_out, 32'd7);
        rd(32'h0C, 32'h2, 1'b1, 5, "status_coll");
        wr(32'h0C, 32'h7, 5, "w1c_coll");
        rd(32'h00, 32'd7, 1'b1, 5, "rd_ctrl");

        // FLR aborts an in-flight read; registers retained
        wr(32'h08, 32'd10, 5, "wr_dly10");
        pulse(32'h04, '0, 1'b0, 1'b1);
        repeat (3) tick();
        flr_assert = 1'b1;
        tick();
        flr_assert = 1'b0;
        repeat (20) tick();
        rd(32'h04, 32'hA5A5_0001, 1'b1, 12, "rd_after_flr");
        wr(32'h08, 32'd0, 12, "wr_dly0");

        // Access counters
        wr(32'h10, 32'd0, 2, "clr_wr_cnt");
        wr(32'h04, 32'h1, 2, "cnt_wr1");
        wr(32'h04, 32'h2, 2, "cnt_wr2");
        wr(32'h04, 32'h3, 2, "cnt_wr3");
        rd(32'h10, 32'd3, 1'b1, 2, "wr_cnt_3");
        wr(32'h14, 32'd0, 2, "clr_rd_cnt");
        rd(32'h14, 32'd0, 1'b1, 2, "rd_cnt_0");
        rd(32'h14, 32'd1, 1'b1, 2, "rd_cnt_1");
        rd(32'h10, 32'd4, 1'b1, 2, "wr_cnt_4");

        // External status, cycle counter snapshot
        status_in = 32'h1234_5678;
        rd(32'h24, 32'h1234_5678, 1'b1, 2, "rd_status_in");
        rd(32'h18, '0, 1'b0, 2, "rd_cyc_lo");
        rd(32'h1C, 32'd0, 1'b1, 2, "rd_cyc_hi");

        // WR_CNT saturation
        force dut.wr_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_q;
        wr(32'h04, 32'h5, 2, "wr_sat");
        rd(32'h10, 32'hFFFF_FFFF, 1'b1, 2, "wr_cnt_sat");

        // Asynchronous reset while waiting
        wr(32'h08, 32'd10, 2, "wr_dly10b");
        pulse(32'h04, '0, 1'b0, 1'b1);
        repeat (3) tick();
        sync_rst_n = 1'b0;
        #1;
        check32("midrst_ack",  32'(cfg_ack), 32'd0);
        check32("midrst_ctrl", ctrl_out,     32'd0);
        tick(); tick();
        sync_rst_n = 1'b1;
        last_rd       = '0;
        last_rd_known = 1'b1;
        repeat (15) tick();
        rd(32'h08, 32'd0, 1'b1, 2, "dly_after_rst");
        rd(32'h04, 32'd0, 1'b1, 2, "scratch_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
